cmp_seq_ctrl: RTL and testbench
===============================

# cmp_seq_ctrl

- Sequential controller that checks two WIDTH-bit words for equality using one shared 2-bit equality comparator (`comparator`: in1..in4 -> out1).
- Slices the operands into 2-bit chunks and drives them onto the comparator one per cycle, most significant chunk first.
- Accumulates the result and reports equal/mismatch through a start/busy/done handshake.
- Sits between the datapath's operand registers and the comparator instance; the comparator itself is unchanged.

## Interface
- WIDTH, 8, operand width; must be even and >= 2. N = WIDTH/2 chunks.
- IDXW, derived: max(1, clog2(N)); width of the chunk index.

- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; accepted only when busy=0.
- a  in  WIDTH  operand A; sampled on the accepting edge.
- b  in  WIDTH  operand B; sampled on the accepting edge.
- busy  out  1  high from the cycle after acceptance until done clears.
- done  out  1  one-cycle pulse; result valid.
- equal  out  1  1 = all compared chunks matched.
- mism_idx  out  IDXW  index of the most significant mismatching chunk; 0 when equal.
- cmp_in1, cmp_in2  out  1  A chunk bit hi, bit lo; connect to comparator in1, in2.
- cmp_in3, cmp_in4  out  1  B chunk bit hi, bit lo; connect to comparator in3, in4.
- cmp_out1  in  1  comparator result; 1 = chunks equal. Combinational path from cmp_in*.

## Operation
- FSM states: IDLE, COMPARE, DONE.
- IDLE:
  - On start=1, latch a and b into internal registers.
  - Set k = N-1, clear the mismatch flag, go to COMPARE.
  - start is ignored in every other state.
- COMPARE:
  - Drive chunk k: cmp_in1 = A[2k+1], cmp_in2 = A[2k], cmp_in3 = B[2k+1], cmp_in4 = B[2k].
  - Sample cmp_out1 at the end of the cycle.
  - On the first mismatch, set the flag and record mism_idx = k. Later mismatches do not overwrite it.
  - When k = 0 and the run has not ended early, go to DONE. Otherwise decrement k.
- DONE:
  - done = 1 for exactly one cycle; equal = !flag.
  - Return to IDLE.
- busy = 1 in COMPARE and DONE.
- equal and mism_idx update on entry to DONE and hold until the next DONE.
- Reset values: busy=0, done=0, equal=0, mism_idx=0, cmp_in1..4=0, state IDLE.
- cmp_in1..4 are 0 whenever the state is not COMPARE.
- Reset mid-operation aborts immediately: no done pulse; all outputs return to reset values.
- WIDTH=2: a single COMPARE cycle; mism_idx is always 0.

## Timing
- Edge 0: start accepted.
- Cycles 1..N: COMPARE. Cycle N+1: done=1. This is the full-run latency.
- Early exit ends COMPARE in the mismatch cycle; done follows in the next cycle.
- Back-to-back: start may be asserted in the done cycle but is ignored because busy=1. The earliest acceptance is the first cycle with busy=0.
- No combinational path from start, a or b to any output. cmp_in* are registered-state decodes.

## Configuration
- CMP_SEQ_EARLY_EXIT_EN defined:
  - COMPARE jumps to DONE in the cycle of the first mismatch.
  - Mismatch latency = (N - k) + 1 cycles after acceptance, where k is the mismatching chunk.
- CMP_SEQ_EARLY_EXIT_EN undefined:
  - All N chunks are always compared; latency is fixed at N+1.
  - equal and mism_idx are identical to the defined case.

## Test plan
- WIDTH=8, a=b=0xA5, start pulse:
  - busy=1 for cycles 1..5, done at cycle 5 (N=4), equal=1, mism_idx=0.
  - cmp_in1..4 sequence 1,0,1,0 | 1,0,1,0 | 0,1,0,1 | 0,1,0,1.
- WIDTH=8, a=0x80, b=0x00:
  - Early exit defined: done at cycle 2.
  - Early exit undefined: done at cycle 5.
  - Both builds: equal=0, mism_idx=3.
- WIDTH=8, a=0x41, b=0x00:
  - equal=0, mism_idx=3 (MSB-first priority).
  - Without early exit: done at cycle 5, and the chunk-0 mismatch does not overwrite mism_idx.
- WIDTH=8, second start while busy with different operands:
  - The second start is ignored; the result reflects the first operands.
  - A new start in the cycle after done is accepted.
- Assert rst in cycle 2 of a compare:
  - All outputs read 0 immediately; no done pulse.
  - The next start after rst falls completes normally.
- WIDTH=2, all 16 (a,b) combinations:
  - equal=1 exactly when a==b, done at cycle 2 each time.
  - Matches the comparator truth table (out1=1 for 0000, 0101, 1010, 1111).

Source files
------------

// File: rtl/cmp_seq_ctrl.sv
// cmp_seq_ctrl: compares two WIDTH-bit words for equality. It feeds one 2-bit chunk per cycle,
// most significant chunk first, to an external combinational 2-bit equality comparator.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   start             request, accepted only while busy = 0
//   a, b              operands, sampled on the accepting edge
//   busy              high in COMPARE and DONE
//   done              one-cycle result-valid pulse
//   equal             1 = all compared chunks matched (held until the next DONE)
//   mism_idx          index of the most significant mismatching chunk, 0 when equal
//   cmp_in1..cmp_in4  A chunk hi/lo, B chunk hi/lo to the comparator; 0 outside COMPARE
//   cmp_out1          comparator result, 1 = chunks equal
//
// Build option: define CMP_SEQ_EARLY_EXIT_EN to leave COMPARE in the cycle of the first
// mismatch. The default build always compares all chunks; results are identical either way.

module cmp_seq_ctrl #(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned N    = WIDTH / 2,
  localparam int unsigned IDXW = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             equal,
  output logic [IDXW-1:0]  mism_idx,
  output logic             cmp_in1,
  output logic             cmp_in2,
  output logic             cmp_in3,
  output logic             cmp_in4,
  input  logic             cmp_out1
);

  localparam logic [IDXW-1:0] KMax = IDXW'(N - 1);

  typedef enum logic [1:0] {StIdle, StCompare, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [IDXW-1:0]  k_q, k_d;
  logic             flag_q, flag_d;
  logic [IDXW-1:0]  first_q, first_d;
  logic             equal_q, equal_d;
  logic [IDXW-1:0]  mism_idx_q, mism_idx_d;

  // Mismatch bookkeeping including the current cycle's comparator result, so a
  // mismatch in the last compared chunk is visible on the edge that enters DONE.
  logic             flag_now;
  logic [IDXW-1:0]  first_now;
  logic             last_chunk;
  logic [WIDTH-1:0] a_sh, b_sh;

  always_comb begin
    flag_now  = flag_q | ~cmp_out1;
    first_now = (!flag_q && !cmp_out1) ? k_q : first_q;
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    k_d        = k_q;
    flag_d     = flag_q;
    first_d    = first_q;
    equal_d    = equal_q;
    mism_idx_d = mism_idx_q;
    last_chunk = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          k_d     = KMax;
          flag_d  = 1'b0;
          first_d = '0;
          state_d = StCompare;
        end
      end
      StCompare: begin
        flag_d     = flag_now;
        first_d    = first_now;
        k_d        = k_q - 1'b1;
        last_chunk = (k_q == '0);
`ifdef CMP_SEQ_EARLY_EXIT_EN
        if (!cmp_out1) last_chunk = 1'b1;
`endif
        if (last_chunk) begin
          state_d    = StDone;
          equal_d    = ~flag_now;
          mism_idx_d = flag_now ? first_now : '0;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      a_q        <= '0;
      b_q        <= '0;
      k_q        <= '0;
      flag_q     <= 1'b0;
      first_q    <= '0;
      equal_q    <= 1'b0;
      mism_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      k_q        <= k_d;
      flag_q     <= flag_d;
      first_q    <= first_d;
      equal_q    <= equal_d;
      mism_idx_q <= mism_idx_d;
    end
  end

  // Chunk k sits at bits [2k+1:2k]; shifting by {k, 0} brings it to [1:0].
  always_comb begin
    a_sh     = a_q >> {k_q, 1'b0};
    b_sh     = b_q >> {k_q, 1'b0};
    cmp_in1  = (state_q == StCompare) & a_sh[1];
    cmp_in2  = (state_q == StCompare) & a_sh[0];
    cmp_in3  = (state_q == StCompare) & b_sh[1];
    cmp_in4  = (state_q == StCompare) & b_sh[0];
    busy     = (state_q != StIdle);
    done     = (state_q == StDone);
    equal    = equal_q;
    mism_idx = mism_idx_q;
  end

endmodule

// File: tb/tb_cmp_seq_ctrl.sv
// Self-checking bench for cmp_seq_ctrl: a WIDTH=8 and a WIDTH=2 instance, each wired to a
// behavioural 2-bit equality comparator, checked against a chunk-level reference model.
module tb_cmp_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, sel;
  logic [7:0] a_drv, b_drv;

  // WIDTH=8 instance
  logic       s8, busy8, done8, eq8, i1_8, i2_8, i3_8, i4_8, o8;
  logic [1:0] idx8;
  // WIDTH=2 instance
  logic       s2, busy2, done2, eq2, i1_2, i2_2, i3_2, i4_2, o2;
  logic [0:0] idx2;

  assign s8 = start & ~sel;
  assign s2 = start & sel;
  assign o8 = (i1_8 == i3_8) && (i2_8 == i4_8);
  assign o2 = (i1_2 == i3_2) && (i2_2 == i4_2);

  cmp_seq_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(s8), .a(a_drv), .b(b_drv),
    .busy(busy8), .done(done8), .equal(eq8), .mism_idx(idx8),
    .cmp_in1(i1_8), .cmp_in2(i2_8), .cmp_in3(i3_8), .cmp_in4(i4_8), .cmp_out1(o8)
  );

  cmp_seq_ctrl #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(s2), .a(a_drv[1:0]), .b(b_drv[1:0]),
    .busy(busy2), .done(done2), .equal(eq2), .mism_idx(idx2),
    .cmp_in1(i1_2), .cmp_in2(i2_2), .cmp_in3(i3_2), .cmp_in4(i4_2), .cmp_out1(o2)
  );

  // Views of whichever instance is selected.
  logic       busy_v, done_v, eq_v;
  logic [1:0] idx_v;
  logic [3:0] cin_v;
  assign busy_v = sel ? busy2 : busy8;
  assign done_v = sel ? done2 : done8;
  assign eq_v   = sel ? eq2 : eq8;
  assign idx_v  = sel ? {1'b0, idx2} : idx8;
  assign cin_v  = sel ? {i1_2, i2_2, i3_2, i4_2} : {i1_8, i2_8, i3_8, i4_8};

  int n_cmp = 0;
  int n_err = 0;

  // Observations from the last run_op.
  int         obs_lat;
  logic       obs_eq, obs_busy_ok;
  logic [1:0] obs_idx;
  logic [3:0] trace_q[$];

  // Reference model: chunk-level comparison of the operands.
  function automatic int ref_idx(input logic [7:0] av, input logic [7:0] bv, input int n);
    for (int i = n - 1; i >= 0; i--)
      if (((av >> (2 * i)) & 8'h3) != ((bv >> (2 * i)) & 8'h3)) return i;
    return 0;
  endfunction

  function automatic int ref_lat(input logic [7:0] av, input logic [7:0] bv, input int n);
    int lat;
    lat = n + 1;
`ifdef CMP_SEQ_EARLY_EXIT_EN
    if (av != bv) lat = (n - ref_idx(av, bv, n)) + 1;
`endif
    return lat;
  endfunction

  // Start one operation and observe it up to the idle cycle after done (bounded).
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv);
    @(negedge clk);
    a_drv = av; b_drv = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    obs_lat = 0; obs_busy_ok = 1'b1; obs_eq = 1'bx; obs_idx = 2'bxx;
    trace_q.delete();
    for (int c = 1; c <= 40; c++) begin
      if (!busy_v) obs_busy_ok = 1'b0;
      if (done_v) begin
        obs_lat = c; obs_eq = eq_v; obs_idx = idx_v;
        if (cin_v != 4'h0) obs_busy_ok = 1'b0;
        break;
      end
      trace_q.push_back(cin_v);
      @(negedge clk);
    end
    @(negedge clk);
    if (busy_v || done_v) obs_busy_ok = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; sel = 1'b0; a_drv = '0; b_drv = '0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy8, done8, eq8, idx8, i1_8, i2_8, i3_8, i4_8} !== 10'h0) begin
      n_err++;
      $display("FAIL reset8: got %b want 0", {busy8, done8, eq8, idx8, i1_8, i2_8, i3_8, i4_8});
    end
    n_cmp++;
    if ({busy2, done2, eq2, idx2, i1_2, i2_2, i3_2, i4_2} !== 9'h0) begin
      n_err++;
      $display("FAIL reset2: got %b want 0", {busy2, done2, eq2, idx2, i1_2, i2_2, i3_2, i4_2});
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({busy8, done8} !== 2'b00) begin
      n_err++;
      $display("FAIL idle_after_reset: got %b want 00", {busy8, done8});
    end
  endtask

  task automatic test_directed;
    logic [15:0] tr;
    sel = 1'b0;
    run_op(8'hA5, 8'hA5);
    tr = '0;
    foreach (trace_q[i]) tr = {tr[11:0], trace_q[i]};
    n_cmp++;
    if ({obs_lat, obs_eq, obs_idx, obs_busy_ok} !== {32'd5, 1'b1, 2'd0, 1'b1}) begin
      n_err++;
      $display("FAIL a5_eq: got lat=%0d eq=%b idx=%0d busy_ok=%b want lat=5 eq=1 idx=0 busy_ok=1",
               obs_lat, obs_eq, obs_idx, obs_busy_ok);
    end
    n_cmp++;
    if (trace_q.size() != 4 || tr !== 16'hAA55) begin
      n_err++;
      $display("FAIL a5_trace: got n=%0d seq=%h want n=4 seq=aa55", trace_q.size(), tr);
    end
    run_op(8'h80, 8'h00);
    n_cmp++;
`ifdef CMP_SEQ_EARLY_EXIT_EN
    if ({obs_lat, obs_eq, obs_idx} !== {32'd2, 1'b0, 2'd3}) begin
`else
    if ({obs_lat, obs_eq, obs_idx} !== {32'd5, 1'b0, 2'd3}) begin
`endif
      n_err++;
      $display("FAIL msb_mism: got lat=%0d eq=%b idx=%0d want eq=0 idx=3 lat=%0d",
               obs_lat, obs_eq, obs_idx, ref_lat(8'h80, 8'h00, 4));
    end
    run_op(8'h41, 8'h00);
    n_cmp++;
    if ({obs_lat, obs_eq, obs_idx} !== {ref_lat(8'h41, 8'h00, 4), 1'b0, 2'd3}) begin
      n_err++;
      $display("FAIL first_mism_kept: got lat=%0d eq=%b idx=%0d want eq=0 idx=3",
               obs_lat, obs_eq, obs_idx);
    end
  endtask

  task automatic test_random;
    logic [7:0] av, bv;
    int         mode;
    sel = 1'b0;
    for (int it = 0; it < 40; it++) begin
      av   = 8'($urandom);
      mode = int'($urandom_range(0, 2));
      if (mode == 0) bv = av;
      else if (mode == 1) bv = av ^ (8'($urandom_range(1, 3)) << (2 * $urandom_range(0, 3)));
      else bv = 8'($urandom);
      run_op(av, bv);
      n_cmp++;
      if ({obs_lat, obs_eq, obs_idx, obs_busy_ok} !==
          {ref_lat(av, bv, 4), av == bv, 2'(ref_idx(av, bv, 4)), 1'b1}) begin
        n_err++;
        $display("FAIL random a=%h b=%h: got lat=%0d eq=%b idx=%0d busy_ok=%b want lat=%0d eq=%b idx=%0d",
                 av, bv, obs_lat, obs_eq, obs_idx, obs_busy_ok,
                 ref_lat(av, bv, 4), av == bv, ref_idx(av, bv, 4));
      end
    end
  endtask

  task automatic test_back_to_back;
    int c;
    sel = 1'b0;
    @(negedge clk);
    a_drv = 8'h3C; b_drv = 8'h3C; start = 1'b1;
    @(negedge clk);
    a_drv = 8'h3C; b_drv = 8'h0C;  // start held high through busy
    c = 1;
    while (!done_v && c < 40) begin
      @(negedge clk);
      c++;
    end
    n_cmp++;
    if ({c, eq_v, idx_v} !== {ref_lat(8'h3C, 8'h3C, 4), 1'b1, 2'd0}) begin
      n_err++;
      $display("FAIL b2b_first: got lat=%0d eq=%b idx=%0d want lat=%0d eq=1 idx=0",
               c, eq_v, idx_v, ref_lat(8'h3C, 8'h3C, 4));
    end
    @(negedge clk);
    n_cmp++;
    if (busy_v !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_idle: got busy=%b want 0", busy_v);
    end
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (busy_v !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_accept: got busy=%b want 1", busy_v);
    end
    c = 1;
    while (!done_v && c < 40) begin
      @(negedge clk);
      c++;
    end
    n_cmp++;
    if ({c, eq_v, idx_v} !== {ref_lat(8'h3C, 8'h0C, 4), 1'b0, 2'(ref_idx(8'h3C, 8'h0C, 4))}) begin
      n_err++;
      $display("FAIL b2b_second: got lat=%0d eq=%b idx=%0d want lat=%0d eq=0 idx=%0d",
               c, eq_v, idx_v, ref_lat(8'h3C, 8'h0C, 4), ref_idx(8'h3C, 8'h0C, 4));
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    logic saw_done;
    sel = 1'b0;
    run_op(8'h5A, 8'h5A);  // leaves equal=1 so the reset clear is observable
    @(negedge clk);
    a_drv = 8'hF0; b_drv = 8'h0F; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({busy8, done8, eq8, idx8, i1_8, i2_8, i3_8, i4_8} !== 10'h0) begin
      n_err++;
      $display("FAIL reset_mid: got %b want 0", {busy8, done8, eq8, idx8, i1_8, i2_8, i3_8, i4_8});
    end
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done8 || busy8) saw_done = 1'b1;
    end
    n_cmp++;
    if (saw_done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_no_done: got activity=%b want 0", saw_done);
    end
    run_op(8'hC3, 8'hC7);
    n_cmp++;
    if ({obs_lat, obs_eq, obs_idx} !== {ref_lat(8'hC3, 8'hC7, 4), 1'b0, 2'd1}) begin
      n_err++;
      $display("FAIL after_reset: got lat=%0d eq=%b idx=%0d want lat=%0d eq=0 idx=1",
               obs_lat, obs_eq, obs_idx, ref_lat(8'hC3, 8'hC7, 4));
    end
  endtask

  task automatic test_width2;
    logic [7:0] av, bv;
    sel = 1'b1;
    for (int k = 0; k < 16; k++) begin
      av = 8'(k >> 2);
      bv = 8'(k & 3);
      run_op(av, bv);
      n_cmp++;
      if ({obs_lat, obs_eq, obs_idx, obs_busy_ok} !== {32'd2, av == bv, 2'd0, 1'b1} ||
          trace_q.size() != 1 || trace_q[0] !== {av[1:0], bv[1:0]}) begin
        n_err++;
        $display("FAIL w2 a=%0d b=%0d: got lat=%0d eq=%b idx=%0d busy_ok=%b n=%0d want lat=2 eq=%b idx=0",
                 av, bv, obs_lat, obs_eq, obs_idx, obs_busy_ok, trace_q.size(), av == bv);
      end
    end
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_width2();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
